// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the clock/reset sequencer.
//   seq_state_t : sequencer state encoding, also exported on state_dbg.
//   cnt_width   : counter width able to hold values 0 .. n-1, derived with $clog2.
//   max3        : largest of three timing parameters, used to size the shared state timer.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_t;

  localparam int unsigned StateW    = 3;
  localparam int unsigned LockLossW = 8;

  // Width of a counter that must represent 0 .. n-1 (minimum one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset; output reads 0 while in reset
//   d   : asynchronous input level
//   q   : synchronized output, two clk edges behind d
module bit_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Power-up / recovery sequencer for the 27 MHz -> 48 MHz rPLL and the downstream reset
// domains. Runs on the reference clock so it keeps working while the PLL is down.
// Pulses pll_rst, waits for a filtered lock, then releases the domains one at a time.
// Loss of lock or a software request re-sequences; repeated lock timeouts latch fault.
// Ports:
//   clk_in        : 27 MHz reference clock
//   rst           : asynchronous active-high reset
//   pll_lock      : rPLL LOCK (asynchronous, synchronized internally)
//   sw_rst_req    : software reset request, rising edge captured
//   pll_rst       : rPLL RESET, active-high
//   domain_rst    : per-domain resets, active-high, domain 0 released first
//   ready         : all domains released and lock good
//   fault         : lock retries exhausted
//   sw_rst_ack    : one-cycle pulse when a pending software request completes
//   lock_loss_cnt : saturating count of lock losses in RELEASE/RUN
//   state_dbg     : current state encoding
// Build option: define RESET_SEQ_STATUS_EN to make lock_loss_cnt and state_dbg live;
// otherwise both read 0 and the loss counter is not built.
module reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int unsigned N_DOMAINS      = 3,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_FILTER    = 64,
  parameter int unsigned LOCK_TIMEOUT   = 27000,
  parameter int unsigned GAP_CYCLES     = 32,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 pll_lock,
  input  logic                 sw_rst_req,
  output logic                 pll_rst,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 ready,
  output logic                 fault,
  output logic                 sw_rst_ack,
  output logic [7:0]           lock_loss_cnt,
  output logic [2:0]           state_dbg
);

  localparam int unsigned CntW   = cnt_width(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, GAP_CYCLES));
  localparam int unsigned FiltW  = cnt_width(LOCK_FILTER + 1);
  localparam int unsigned RetryW = cnt_width(MAX_RETRIES + 1);
  localparam int unsigned IdxW   = cnt_width(N_DOMAINS);

  seq_state_t            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;      // shared per-state timer
  logic [FiltW-1:0]      filt_q, filt_d;
  logic [RetryW-1:0]     retry_q, retry_d;
  logic [IdxW-1:0]       idx_q, idx_d;      // next domain to release
  logic                  pending_q, pending_d;
  logic                  sw_prev_q;
  logic                  pll_rst_q, pll_rst_d;
  logic [N_DOMAINS-1:0]  dom_q, dom_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;
  logic                  ack_q, ack_d;
  logic                  lock_sync;
  logic                  lock_ok;
  logic                  sw_edge;

  bit_sync_2ff u_lock_sync (
    .clk (clk_in),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_sync)
  );

  assign sw_edge = sw_rst_req & ~sw_prev_q;
  // Accept lock on the edge where the filter would reach LOCK_FILTER; >= also covers a
  // filter already saturated when WAIT_LOCK is entered.
  assign lock_ok = lock_sync && (filt_q >= FiltW'(LOCK_FILTER - 1));

  always_comb begin
    filt_d = filt_q;
    if (!lock_sync) begin
      filt_d = '0;
    end else if (filt_q != FiltW'(LOCK_FILTER)) begin
      filt_d = filt_q + FiltW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    idx_d     = idx_q;
    pll_rst_d = pll_rst_q;
    dom_d     = dom_q;
    ready_d   = ready_q;
    fault_d   = fault_q;
    ack_d     = 1'b0;
    // A new request edge always wins over a same-cycle clear.
    pending_d = pending_q | sw_edge;

    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == CntW'(PLL_RST_CYCLES - 1)) begin
          state_d   = WAIT_LOCK;
          pll_rst_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      WAIT_LOCK: begin
        if (lock_ok) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
          cnt_d   = '0;
          retry_d = retry_q + RetryW'(1);
          if (retry_d == RetryW'(MAX_RETRIES)) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            state_d   = PLL_RST;
            pll_rst_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      RELEASE, RUN: begin
        if (!lock_sync) begin
          // Lock loss takes priority over any pending software request.
          state_d   = PLL_RST;
          pll_rst_d = 1'b1;
          cnt_d     = '0;
          dom_d     = '1;
          ready_d   = 1'b0;
          retry_d   = '0;
        end else if (state_q == RELEASE) begin
          if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
            cnt_d        = '0;
            dom_d[idx_q] = 1'b0;
            if (idx_q == IdxW'(N_DOMAINS - 1)) begin
              state_d = RUN;
              ready_d = 1'b1;
              if (pending_q) begin
                ack_d     = 1'b1;
                pending_d = sw_edge;
              end
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (pending_q) begin
          // Soft reset re-releases the domains without touching the PLL.
          state_d = RELEASE;
          dom_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      FAULT: begin
        if (pending_q) begin
          state_d   = PLL_RST;
          pll_rst_d = 1'b1;
          cnt_d     = '0;
          fault_d   = 1'b0;
          retry_d   = '0;
        end
      end

      default: begin
        state_d   = PLL_RST;
        pll_rst_d = 1'b1;
        cnt_d     = '0;
        dom_d     = '1;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      filt_q    <= '0;
      retry_q   <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      sw_prev_q <= 1'b0;
      pll_rst_q <= 1'b1;
      dom_q     <= '1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      filt_q    <= filt_d;
      retry_q   <= retry_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      sw_prev_q <= sw_rst_req;
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      ack_q     <= ack_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign domain_rst = dom_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign sw_rst_ack = ack_q;

`ifdef RESET_SEQ_STATUS_EN
  logic                 loss_evt;
  logic [LockLossW-1:0] loss_cnt_q;

  assign loss_evt = ((state_q == RELEASE) || (state_q == RUN)) && !lock_sync;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if (loss_evt && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + LockLossW'(1);
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
  assign state_dbg     = state_q;
`else
  assign lock_loss_cnt = '0;
  assign state_dbg     = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed-sequence bench for reset_sequencer with randomized lock delays, glitch
// positions and hold times. Expected values come from arithmetic on the sequencing
// rules (pulse widths, filter latency, release spacing), not from the DUT.
module tb_reset_sequencer;

  localparam int unsigned NDom    = 3;
  localparam int unsigned PllCyc  = 4;
  localparam int unsigned Filt    = 8;
  localparam int unsigned Tmo     = 100;
  localparam int unsigned Gap     = 5;
  localparam int unsigned Retries = 2;

`ifdef RESET_SEQ_STATUS_EN
  localparam bit StatusEn = 1'b1;
`else
  localparam bit StatusEn = 1'b0;
`endif

  localparam logic [2:0] SPll   = 3'd0;
  localparam logic [2:0] SWait  = 3'd1;
  localparam logic [2:0] SRel   = 3'd2;
  localparam logic [2:0] SRun   = 3'd3;
  localparam logic [2:0] SFault = 3'd4;

  logic            clk_in     = 1'b0;
  logic            rst        = 1'b1;
  logic            pll_lock   = 1'b0;
  logic            sw_rst_req = 1'b0;
  logic            pll_rst;
  logic [NDom-1:0] domain_rst;
  logic            ready;
  logic            fault;
  logic            sw_rst_ack;
  logic [7:0]      lock_loss_cnt;
  logic [2:0]      state_dbg;

  int errors  = 0;
  int checks  = 0;
  int exp_llc = 0;

  always #5 clk_in = ~clk_in;

  reset_sequencer #(
    .N_DOMAINS      (NDom),
    .PLL_RST_CYCLES (PllCyc),
    .LOCK_FILTER    (Filt),
    .LOCK_TIMEOUT   (Tmo),
    .GAP_CYCLES     (Gap),
    .MAX_RETRIES    (Retries)
  ) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .pll_lock      (pll_lock),
    .sw_rst_req    (sw_rst_req),
    .pll_rst       (pll_rst),
    .domain_rst    (domain_rst),
    .ready         (ready),
    .fault         (fault),
    .sw_rst_ack    (sw_rst_ack),
    .lock_loss_cnt (lock_loss_cnt),
    .state_dbg     (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [2:0] exp);
    check({tag, "_state"}, 32'(state_dbg), StatusEn ? 32'(exp) : 32'd0);
  endtask

  task automatic check_llc(input string tag);
    check({tag, "_llc"}, 32'(lock_loss_cnt), StatusEn ? 32'(exp_llc) : 32'd0);
  endtask

  // Starts on the sample where PLL_RST has just been entered: pll_rst is high for
  // PllCyc samples in total and low on the next.
  task automatic check_pll_pulse(input string tag);
    for (int k = 1; k <= PllCyc; k++) begin
      step();
      check({tag, "_pllrst"}, 32'(pll_rst), 32'(k < PllCyc));
      check({tag, "_dom"}, 32'(domain_rst), 32'({NDom{1'b1}}));
    end
    check_state(tag, SWait);
  endtask

  // Starts at WAIT_LOCK entry with lock low. Lock rises after d cycles; an optional
  // one-cycle glitch follows g high cycles. RELEASE is entered Filt+2 edges after the
  // final rising edge of pll_lock.
  task automatic wait_lock(input string tag, input int d, input int g);
    for (int k = 0; k < d; k++) begin
      step();
      check({tag, "_prelock_pllrst"}, 32'(pll_rst), 32'd0);
      check({tag, "_prelock_dom"}, 32'(domain_rst), 32'({NDom{1'b1}}));
    end
    pll_lock = 1'b1;
    if (g > 0) begin
      repeat (g) step();
      pll_lock = 1'b0;
      step();
      pll_lock = 1'b1;
    end
    for (int k = 1; k <= int'(Filt) + 2; k++) begin
      step();
      check({tag, "_filter_dom"}, 32'(domain_rst), 32'({NDom{1'b1}}));
      if (k == int'(Filt) + 1) check_state({tag, "_early"}, SWait);
    end
    check_state(tag, SRel);
  endtask

  // Starts at RELEASE entry: domain k clears (k+1)*Gap cycles later; ready (and the ack,
  // when a request is pending) arrive with the last release.
  task automatic check_release(input string tag, input bit exp_ack);
    for (int s = 1; s <= int'(NDom * Gap); s++) begin
      int              rel;
      logic [NDom-1:0] exp_dom;
      step();
      rel     = s / int'(Gap);
      exp_dom = '1;
      exp_dom = exp_dom << rel;
      check({tag, "_dom"}, 32'(domain_rst), 32'(exp_dom));
      check({tag, "_ready"}, 32'(ready), 32'(s == int'(NDom * Gap)));
      check({tag, "_ack"}, 32'(sw_rst_ack), 32'(exp_ack && (s == int'(NDom * Gap))));
      check({tag, "_pllrst"}, 32'(pll_rst), 32'd0);
    end
    check_state(tag, SRun);
    step();
    check({tag, "_ack_done"}, 32'(sw_rst_ack), 32'd0);
    check({tag, "_ready_hold"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int d;
    int g;
    int hold;

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    check("rst_pllrst", 32'(pll_rst), 32'd1);
    check("rst_dom", 32'(domain_rst), 32'({NDom{1'b1}}));
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_ack", 32'(sw_rst_ack), 32'd0);
    check_llc("rst");
    check_state("rst", SPll);
    rst = 1'b0;

    // Clean boot, lock 10 cycles after pll_rst falls
    check_pll_pulse("boot");
    wait_lock("boot", 10, 0);
    check_release("boot_rel", 1'b0);
    hold = $urandom_range(3, 20);
    for (int k = 0; k < hold; k++) begin
      step();
      check("run_ready", 32'(ready), 32'd1);
      check("run_dom", 32'(domain_rst), 32'd0);
    end

    // Lock loss in RUN: domains reset three cycles after the drop
    pll_lock = 1'b0;
    step();
    check("loss_c1_dom", 32'(domain_rst), 32'd0);
    step();
    check("loss_c2_ready", 32'(ready), 32'd1);
    step();
    check("loss_c3_dom", 32'(domain_rst), 32'({NDom{1'b1}}));
    check("loss_c3_ready", 32'(ready), 32'd0);
    check("loss_c3_pllrst", 32'(pll_rst), 32'd1);
    exp_llc++;
    check_llc("loss");
    check_state("loss", SPll);
    check_pll_pulse("loss");
    d = $urandom_range(0, 50);
    g = $urandom_range(1, Filt - 1);
    wait_lock("glitch", d, g);
    check_release("loss_rel", 1'b0);

    // Software request in RUN: PLL untouched, domains re-released, single ack
    repeat ($urandom_range(2, 10)) step();
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    check("sw_c1_dom", 32'(domain_rst), 32'd0);
    step();
    check("sw_c2_dom", 32'(domain_rst), 32'({NDom{1'b1}}));
    check("sw_c2_ready", 32'(ready), 32'd0);
    check("sw_c2_pllrst", 32'(pll_rst), 32'd0);
    check_state("sw_c2", SRel);
    check_release("sw_rel", 1'b1);
    check_llc("sw");

    // Asynchronous reset mid-run takes effect without a clock edge
    repeat ($urandom_range(1, 5)) step();
    rst      = 1'b1;
    pll_lock = 1'b0;
    #2;
    exp_llc = 0;
    check("arst_dom", 32'(domain_rst), 32'({NDom{1'b1}}));
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_pllrst", 32'(pll_rst), 32'd1);
    check_llc("arst");
    step();
    rst = 1'b0;

    // Lock never arrives: two timeouts with a PLL pulse between, then FAULT
    check_pll_pulse("to1");
    for (int k = 1; k <= int'(Tmo); k++) begin
      step();
      check("to1_pllrst", 32'(pll_rst), 32'(k == int'(Tmo)));
      check("to1_fault", 32'(fault), 32'd0);
    end
    check_pll_pulse("to2");
    for (int k = 1; k <= int'(Tmo); k++) begin
      step();
      check("to2_fault", 32'(fault), 32'(k == int'(Tmo)));
      check("to2_pllrst", 32'(pll_rst), 32'd0);
      check("to2_dom", 32'(domain_rst), 32'({NDom{1'b1}}));
    end
    check_state("to2", SFault);
    hold = $urandom_range(2, 15);
    for (int k = 0; k < hold; k++) begin
      step();
      check("fault_hold", 32'(fault), 32'd1);
      check("fault_pllrst", 32'(pll_rst), 32'd0);
      check("fault_ready", 32'(ready), 32'd0);
    end

    // Software request in FAULT, then a normal boot that ends with the ack
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    check("swf_c1_fault", 32'(fault), 32'd1);
    step();
    check("swf_c2_fault", 32'(fault), 32'd0);
    check("swf_c2_pllrst", 32'(pll_rst), 32'd1);
    check_state("swf_c2", SPll);
    check_pll_pulse("swf");
    d = $urandom_range(0, 50);
    wait_lock("swf", d, 0);
    check_release("swf_rel", 1'b1);
    check("swf_fault", 32'(fault), 32'd0);
    check_llc("swf");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
